// File: rtl/alu_writeback_unit_if.sv
// ALU result interface: the execute stage presents one result bundle per handshake.
// The master drives the bundle; the slave (the writeback unit) returns in_ready.
interface alu_writeback_unit_if #(
    parameter int REG_ADDR_W = 3,
    parameter int DATA_W     = 16
) ();

    logic                  in_valid;
    logic                  in_ready;
    logic [REG_ADDR_W-1:0] in_rd;
    logic                  in_dual;
    logic                  in_flags_en;
    logic [DATA_W-1:0]     in_result_0;
    logic [DATA_W-1:0]     in_result_1;
    logic [DATA_W-1:0]     in_flags;

    modport master (
        output in_valid,
        input  in_ready,
        output in_rd,
        output in_dual,
        output in_flags_en,
        output in_result_0,
        output in_result_1,
        output in_flags
    );

    modport slave (
        input  in_valid,
        output in_ready,
        input  in_rd,
        input  in_dual,
        input  in_flags_en,
        input  in_result_0,
        input  in_result_1,
        input  in_flags
    );

endinterface

// File: rtl/alu_writeback_unit.sv
// ALU writeback unit: drains ALU result bundles into a single-write-port register
// file and the flag register. Dual-result ops are split into two write beats
// (result_0 to rd, result_1 to rd+1) and the execute stage is stalled for the
// second beat. All outputs come from registers.
module alu_writeback_unit #(
    parameter int REG_ADDR_W  = 3,
    parameter int DATA_W      = 16,
    parameter int ZERO_REG_RO = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    alu_writeback_unit_if.slave   alu,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0]     rf_wdata,
    output logic                  flag_we,
    output logic [DATA_W-1:0]     flags_out,
    output logic                  busy,
    output logic [15:0]           wb_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR0  = 2'd1,
        WR1  = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    // Only the fields needed after the WR0 beat are kept; the WR0 fields go
    // straight into the output registers at the accepting edge.
    logic [REG_ADDR_W-1:0] lat_rd;
    logic                  lat_dual;
    logic [DATA_W-1:0]     lat_result_1;

    logic                  in_ready_c;
    logic                  accept;

    logic                  beat_valid;
    logic [REG_ADDR_W-1:0] beat_addr;
    logic [DATA_W-1:0]     beat_data;
    logic                  beat_flag_we;
    logic                  beat_is_wr0;
    logic                  beat_suppress;

    // Ready whenever no second beat is still owed; never looks at in_valid.
    always_comb begin
        in_ready_c = 1'b0;
        accept     = 1'b0;
        if (!flush) begin
            unique case (state)
                IDLE:    in_ready_c = 1'b1;
                WR0:     in_ready_c = !lat_dual;
                WR1:     in_ready_c = 1'b1;
                default: in_ready_c = 1'b0;
            endcase
        end
        accept = alu.in_valid && in_ready_c;
    end

    assign alu.in_ready = in_ready_c;
    assign busy         = (state != IDLE);

    // Next state plus the beat that will be shown on the outputs in that state.
    always_comb begin
        next_state    = IDLE;
        beat_valid    = 1'b0;
        beat_addr     = '0;
        beat_data     = '0;
        beat_flag_we  = 1'b0;
        beat_is_wr0   = 1'b0;
        beat_suppress = 1'b0;

        if (!flush) begin
            unique case (state)
                IDLE: begin
                    if (accept) next_state = WR0;
                end
                WR0: begin
                    if (lat_dual)    next_state = WR1;
                    else if (accept) next_state = WR0;
                end
                WR1: begin
                    if (accept) next_state = WR0;
                end
                default: next_state = IDLE;
            endcase
        end

        unique case (next_state)
            WR0: begin
                beat_valid   = 1'b1;
                beat_is_wr0  = 1'b1;
                beat_addr    = alu.in_rd;
                beat_data    = alu.in_result_0;
                beat_flag_we = alu.in_flags_en;
            end
            WR1: begin
                beat_valid   = 1'b1;
                beat_addr    = lat_rd + REG_ADDR_W'(1);
                beat_data    = lat_result_1;
                beat_flag_we = 1'b0;
            end
            default: begin
                beat_valid = 1'b0;
            end
        endcase

        beat_suppress = (ZERO_REG_RO != 0) && (beat_addr == '0);
    end

    // State, latched bundle fields and registered writeback outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            lat_rd       <= '0;
            lat_dual     <= 1'b0;
            lat_result_1 <= '0;
            rf_we        <= 1'b0;
            rf_waddr     <= '0;
            rf_wdata     <= '0;
            flag_we      <= 1'b0;
            flags_out    <= '0;
            wb_count     <= '0;
        end else begin
            state <= next_state;

            if (accept) begin
                lat_rd       <= alu.in_rd;
                lat_dual     <= alu.in_dual;
                lat_result_1 <= alu.in_result_1;
            end

            rf_we   <= beat_valid && !beat_suppress;
            flag_we <= beat_valid && beat_flag_we;

            if (beat_valid) begin
                rf_waddr <= beat_addr;
                rf_wdata <= beat_data;
                wb_count <= wb_count + 16'd1;
            end

            if (beat_is_wr0) begin
                flags_out <= alu.in_flags;
            end
        end
    end

endmodule

// File: tb/tb_alu_writeback_unit.sv
// Self-checking bench for alu_writeback_unit. Two instances share one stimulus
// stream: one with address 0 writable, one with address 0 read-only. The
// reference model is a queue of pending write beats: each accepted bundle
// pushes one or two beats, and each clock shows the next beat or nothing.
module tb_alu_writeback_unit;

    localparam int AW = 3;
    localparam int DW = 16;

    typedef struct {
        int          addr;
        logic [15:0] data;
        logic        wr0;
        logic        fen;
        logic [15:0] flags;
    } beat_t;

    logic clk;
    logic reset;
    logic flush;

    alu_writeback_unit_if #(.REG_ADDR_W(AW), .DATA_W(DW)) bus0 ();
    alu_writeback_unit_if #(.REG_ADDR_W(AW), .DATA_W(DW)) bus1 ();

    logic          rf_we0, rf_we1;
    logic [AW-1:0] rf_waddr0, rf_waddr1;
    logic [DW-1:0] rf_wdata0, rf_wdata1;
    logic          flag_we0, flag_we1;
    logic [DW-1:0] flags_out0, flags_out1;
    logic          busy0, busy1;
    logic [15:0]   wb_count0, wb_count1;

    assign bus1.in_valid    = bus0.in_valid;
    assign bus1.in_rd       = bus0.in_rd;
    assign bus1.in_dual     = bus0.in_dual;
    assign bus1.in_flags_en = bus0.in_flags_en;
    assign bus1.in_result_0 = bus0.in_result_0;
    assign bus1.in_result_1 = bus0.in_result_1;
    assign bus1.in_flags    = bus0.in_flags;

    alu_writeback_unit #(.REG_ADDR_W(AW), .DATA_W(DW), .ZERO_REG_RO(0)) dut0 (
        .clk(clk), .reset(reset), .flush(flush), .alu(bus0.slave),
        .rf_we(rf_we0), .rf_waddr(rf_waddr0), .rf_wdata(rf_wdata0),
        .flag_we(flag_we0), .flags_out(flags_out0), .busy(busy0), .wb_count(wb_count0)
    );

    alu_writeback_unit #(.REG_ADDR_W(AW), .DATA_W(DW), .ZERO_REG_RO(1)) dut1 (
        .clk(clk), .reset(reset), .flush(flush), .alu(bus1.slave),
        .rf_we(rf_we1), .rf_waddr(rf_waddr1), .rf_wdata(rf_wdata1),
        .flag_we(flag_we1), .flags_out(flags_out1), .busy(busy1), .wb_count(wb_count1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int bad;

    beat_t       pend[$];
    logic        exp_we, exp_we1, exp_fwe, exp_busy;
    logic [2:0]  exp_addr;
    logic [15:0] exp_data, exp_flags, exp_count;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkAll();
        checkOutput("rf_we",      32'(rf_we0),     32'(exp_we));
        checkOutput("rf_waddr",   32'(rf_waddr0),  32'(exp_addr));
        checkOutput("rf_wdata",   32'(rf_wdata0),  32'(exp_data));
        checkOutput("flag_we",    32'(flag_we0),   32'(exp_fwe));
        checkOutput("flags_out",  32'(flags_out0), 32'(exp_flags));
        checkOutput("busy",       32'(busy0),      32'(exp_busy));
        checkOutput("wb_count",   32'(wb_count0),  32'(exp_count));
        checkOutput("ro_rf_we",   32'(rf_we1),     32'(exp_we1));
        checkOutput("ro_waddr",   32'(rf_waddr1),  32'(exp_addr));
        checkOutput("ro_wdata",   32'(rf_wdata1),  32'(exp_data));
        checkOutput("ro_flag_we", 32'(flag_we1),   32'(exp_fwe));
        checkOutput("ro_count",   32'(wb_count1),  32'(exp_count));
    endtask

    task automatic applyStimulus(input logic v, input int rd, input logic d, input logic fe,
                                 input logic [15:0] r0, input logic [15:0] r1,
                                 input logic [15:0] fl_val, input logic fl, input logic rs);
        logic  exp_ready;
        logic  acc;
        int    rdm;
        beat_t b;
        rdm               = rd % 8;
        bus0.in_valid     = v;
        bus0.in_rd        = 3'(rdm);
        bus0.in_dual      = d;
        bus0.in_flags_en  = fe;
        bus0.in_result_0  = r0;
        bus0.in_result_1  = r1;
        bus0.in_flags     = fl_val;
        flush             = fl;
        reset             = rs;
        #1;
        exp_ready = !fl && (pend.size() == 0);
        checkOutput("in_ready",    32'(bus0.in_ready), 32'(exp_ready));
        checkOutput("ro_in_ready", 32'(bus1.in_ready), 32'(exp_ready));
        acc = v && exp_ready;
        @(posedge clk);
        if (!rs) begin
            pend.delete();
            exp_we = 0; exp_we1 = 0; exp_fwe = 0; exp_busy = 0;
            exp_addr = 0; exp_data = 0; exp_flags = 0; exp_count = 0;
        end else if (fl) begin
            pend.delete();
            exp_we = 0; exp_we1 = 0; exp_fwe = 0; exp_busy = 0;
        end else begin
            if (acc) begin
                pend.push_back('{addr: rdm, data: r0, wr0: 1'b1, fen: fe, flags: fl_val});
                if (d) pend.push_back('{addr: (rdm + 1) % 8, data: r1, wr0: 1'b0, fen: 1'b0, flags: 16'h0});
            end
            if (pend.size() > 0) begin
                b         = pend.pop_front();
                exp_we    = 1;
                exp_we1   = (b.addr != 0);
                exp_addr  = 3'(b.addr);
                exp_data  = b.data;
                exp_fwe   = b.wr0 && b.fen;
                if (b.wr0) exp_flags = b.flags;
                exp_busy  = 1;
                exp_count = exp_count + 16'd1;
            end else begin
                exp_we = 0; exp_we1 = 0; exp_fwe = 0; exp_busy = 0;
            end
        end
        @(negedge clk);
        checkAll();
    endtask

    task automatic idleCycle();
        applyStimulus(0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 0, 1);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        exp_we = 0; exp_we1 = 0; exp_fwe = 0; exp_busy = 0;
        exp_addr = 0; exp_data = 0; exp_flags = 0; exp_count = 0;
        reset = 1'b0;
        flush = 1'b0;
        bus0.in_valid = 0; bus0.in_rd = 0; bus0.in_dual = 0; bus0.in_flags_en = 0;
        bus0.in_result_0 = 0; bus0.in_result_1 = 0; bus0.in_flags = 0;
        repeat (3) @(negedge clk);
        $display("[TB] reset state");
        applyStimulus(0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 0, 0);
        checkOutput("reset_count_const", 32'(wb_count0), 32'h0);

        $display("[TB] single ADD");
        applyStimulus(1, 2, 0, 1, 16'h1234, 16'h0, 16'h0080, 0, 1);
        checkOutput("add_waddr", 32'(rf_waddr0), 32'd2);
        checkOutput("add_wdata", 32'(rf_wdata0), 32'h1234);
        checkOutput("add_flags", 32'(flags_out0), 32'h0080);
        checkOutput("add_fwe",   32'(flag_we0), 32'd1);
        checkOutput("add_count", 32'(wb_count0), 32'd1);
        idleCycle();
        checkOutput("add_idle_busy", 32'(busy0), 32'd0);

        $display("[TB] MUL dual");
        applyStimulus(1, 3, 1, 0, 16'h5678, 16'h0012, 16'h0, 0, 1);
        checkOutput("mul_wr0_wdata", 32'(rf_wdata0), 32'h5678);
        checkOutput("mul_wr0_ready", 32'(bus0.in_ready), 32'd0);
        idleCycle();
        checkOutput("mul_wr1_waddr", 32'(rf_waddr0), 32'd4);
        checkOutput("mul_wr1_wdata", 32'(rf_wdata0), 32'h0012);
        checkOutput("mul_count",     32'(wb_count0), 32'd3);
        idleCycle();

        $display("[TB] dual wrap rd=7");
        applyStimulus(1, 7, 1, 1, 16'hAAAA, 16'hBEEF, 16'h0001, 0, 1);
        idleCycle();
        checkOutput("wrap_waddr", 32'(rf_waddr0), 32'd0);
        checkOutput("wrap_wdata", 32'(rf_wdata0), 32'hBEEF);
        checkOutput("wrap_we",    32'(rf_we0), 32'd1);
        checkOutput("wrap_ro_we", 32'(rf_we1), 32'd0);
        checkOutput("wrap_ro_count", 32'(wb_count1), 32'd5);
        idleCycle();

        $display("[TB] back-to-back singles then dual");
        for (int i = 1; i <= 4; i++)
            applyStimulus(1, i, 0, i[0], 16'(16'h1000 + i), 16'h0, 16'(i), 0, 1);
        applyStimulus(1, 5, 1, 1, 16'h0505, 16'h0606, 16'h00F0, 0, 1);
        applyStimulus(1, 6, 0, 0, 16'h0707, 16'h0, 16'h0, 0, 1);
        applyStimulus(1, 6, 0, 0, 16'h0707, 16'h0, 16'h0, 0, 1);
        idleCycle();
        idleCycle();

        $display("[TB] flush in WR0 of dual");
        applyStimulus(1, 1, 1, 1, 16'h1111, 16'h2222, 16'h0033, 0, 1);
        applyStimulus(1, 2, 0, 1, 16'h3333, 16'h0, 16'h0044, 1, 1);
        checkOutput("flush_busy", 32'(busy0), 32'd0);
        checkOutput("flush_we",   32'(rf_we0), 32'd0);
        idleCycle();
        applyStimulus(0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 1, 1);

        $display("[TB] reset mid-dual");
        applyStimulus(1, 4, 1, 1, 16'h4444, 16'h5555, 16'h0066, 0, 1);
        applyStimulus(0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 0, 0);
        checkOutput("rst_busy",  32'(busy0), 32'd0);
        checkOutput("rst_count", 32'(wb_count0), 32'd0);
        checkOutput("rst_wdata", 32'(rf_wdata0), 32'd0);
        applyStimulus(1, 6, 0, 1, 16'h6666, 16'h0, 16'h0077, 0, 1);
        checkOutput("reaccept_wdata", 32'(rf_wdata0), 32'h6666);
        idleCycle();

        $display("[TB] random traffic");
        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom_range(0, 9) < 7), int'($urandom_range(0, 7)),
                          ($urandom_range(0, 9) < 4), 1'($urandom_range(0, 1)),
                          16'($urandom), 16'($urandom), 16'($urandom),
                          ($urandom_range(0, 19) == 0), ($urandom_range(0, 49) != 0));
        end

        $display("[TB] wb_count wrap");
        for (int i = 0; i < 65540; i++) begin
            applyStimulus(1, int'($urandom_range(0, 7)), 0, 0, 16'($urandom), 16'h0, 16'h0, 0, 1);
        end
        idleCycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_writeback_unit.md
Name: alu_writeback_unit

Overview:
Consumer end of the ALU result interface. Accepts one ALU result bundle per handshake: result_0, result_1, next_flags, destination register and a dual-result marker. Drains the bundle into the single-write-port register file and the flag register. Dual-result ops (MUL high/low, DIV quotient/remainder) are serialised over two cycles, and the unit back-pressures the execute stage while doing so.

Parameters:
REG_ADDR_W, 3, register-file address width; high-word address wraps modulo 2^REG_ADDR_W
DATA_W, 16, width of result and flag words
ZERO_REG_RO, 0, when 1, any write to address 0 is suppressed (rf_we forced low); the beat still counts as retired

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-low reset
flush  input  1  synchronous pipeline flush; discards pending beats
in_valid  input  1  execute stage presents a result bundle
in_ready  output  1  unit can accept a bundle this cycle
in_rd  input  REG_ADDR_W  destination register for result_0
in_dual  input  1  bundle carries result_1 for register in_rd+1
in_flags_en  input  1  bundle updates the flag register
in_result_0  input  DATA_W  primary result (low product / quotient)
in_result_1  input  DATA_W  secondary result (high product / remainder)
in_flags  input  DATA_W  next_flags value from ALU
rf_we  output  1  register-file write enable
rf_waddr  output  REG_ADDR_W  register-file write address
rf_wdata  output  DATA_W  register-file write data
flag_we  output  1  flag-register write enable
flags_out  output  DATA_W  flag value to write
busy  output  1  state != IDLE
wb_count  output  16  retired-beat counter (one per rf write beat), wraps

Behaviour:
- Reset (reset==0 at clk edge): state=IDLE, rf_we=0, rf_waddr=0, rf_wdata=0, flag_we=0, flags_out=0, wb_count=0, latched bundle cleared. Reset has priority over flush, which has priority over normal operation.
- Accept condition: in_valid && in_ready. in_ready = !flush && (state==IDLE || state==WR0 && !lat_dual || state==WR1). in_ready never depends on in_valid.
- Bundle fields are latched on accept. All outputs are driven from registers, so there is no combinational path from in_* to rf_* or flag_*.
- States IDLE, WR0, WR1:
  - IDLE: outputs idle (rf_we=0, flag_we=0). On accept, go to WR0.
  - WR0: rf_we=1 (unless suppressed), rf_waddr=lat_rd, rf_wdata=lat_result_0, flag_we=lat_flags_en, flags_out=lat_flags.
    - If lat_dual: go to WR1 (in_ready=0).
    - Else: accept in the same cycle goes to WR0 with the new bundle; otherwise go to IDLE.
  - WR1: rf_we=1 (unless suppressed), rf_waddr=lat_rd+1 (mod 2^REG_ADDR_W, e.g. 7 wraps to 0), rf_wdata=lat_result_1, flag_we=0. Accept goes to WR0; otherwise go to IDLE.
- Latency: accept at edge N puts the WR0 beat on the outputs in cycle N+1. For dual bundles, the WR1 beat follows in cycle N+2.
- Throughput: 1 single bundle per cycle; 1 dual bundle per 2 cycles.
- Flags are written exactly once per bundle, on the WR0 beat only, and only if in_flags_en was set.
- Write suppression: when ZERO_REG_RO=1 and the beat address is 0, rf_we=0. rf_waddr and rf_wdata still show the beat values. wb_count still increments.
- wb_count: +1 for each WR0 or WR1 beat; 16'hFFFF+1 wraps to 0.
- Flush:
  - The next state is IDLE. A pending WR1 beat is dropped. No bundle is accepted in the flush cycle.
  - A beat already being driven in the flush cycle completes, because outputs are registered.
  - Flush in IDLE has no effect.
- Reset mid-dual: WR1 is abandoned, and outputs read zero on the next cycle.

Test Plan:
- Single ADD, rd=2, r0=16'h1234, flags_en=1, flags=16'h0080 -> one cycle later: rf_we=1, waddr=2, wdata=16'h1234, flag_we=1, flags_out=16'h0080; wb_count=1; IDLE after.
- MUL dual, rd=3, r0=16'h5678, r1=16'h0012 -> cycle+1: waddr=3, wdata=16'h5678, in_ready=0; cycle+2: waddr=4, wdata=16'h0012, flag_we=0; wb_count=2.
- Dual with rd=7, r1=16'hBEEF -> WR1 beat: waddr=0, wdata=16'hBEEF (wrap). With ZERO_REG_RO=1, rf_we=0 on that beat and wb_count still +1.
- Back-to-back single bundles with in_valid held for 4 cycles (rd=1..4) -> 4 consecutive write cycles, in_ready=1 throughout; then a dual bundle holds in_ready low for exactly 1 cycle.
- Flush asserted in the WR0 cycle of a dual bundle with in_valid=1 -> WR0 beat written, no WR1 beat, no accept that cycle, state=IDLE next.
- reset=0 during WR1 -> next cycle: all outputs 0, busy=0, wb_count=0; re-accept works after reset=1.
